jtframe_serjoy: RTL and testbench
=================================

# jtframe_serjoy

Parametrised serial joystick reader for the DB15 SNAC adapter on the MiSTer user port. It drives a daisy chain of parallel-in/serial-out shift registers (74HC165 style) and scans a configurable number of players and bits per player. Scanning is either continuous or triggered, and per-player presence is detected. An optional two-frame confirmation filter rejects glitches. The block sits in the MiSTer frame layer between the USER_IN/USER_OUT pins and the joystick merge logic; its outputs feed the game joysticks when the OSD serial option is on.

## Interface
Parameters:
- PLAYERS, 2, number of daisy-chained pads, 1..4
- BITS, 12, bits shifted per pad, 2..16
- CLKDIV, 8, system clocks per half-period tick of joy_clk, ≥2
- FILTER, 0, 1 = output updates only when two consecutive raw frames match

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scanner enable (OSD serial option ≠ Off)
- trig  in  1  start request, sampled in IDLE; tie high for continuous scan
- joy_data  in  1  serial data from the chain, active-low buttons
- joy_clk  out  1  shift clock to the chain, idle low
- joy_load  out  1  parallel load, active-low, idle high
- joy_out  out  PLAYERS*BITS  decoded buttons, active-high; player p at [(PLAYERS-p)*BITS-1 -: BITS]
- present  out  PLAYERS  pad detected per player; bit p = player p
- upd  out  1  one-cycle pulse when joy_out/present are (re)written
- busy  out  1  high outside IDLE

## Operation
- Free-running divider div counts 0..CLKDIV-1; tick = (div==CLKDIV-1). The divider runs independently of state.
- Let N = PLAYERS*BITS. Bit counter cnt spans 0..N-1.
- States:
  - IDLE: on tick with en && trig, go to LOAD.
  - LOAD: two ticks. First tick: joy_load=0. Second tick: joy_load=1 (settle). Then SHIFT with cnt=0.
  - SHIFT: 2N ticks in pairs. Phase A tick: sample joy_data into raw shift register (shift left, LSB in, inverted), then set joy_clk=1. Phase B tick: joy_clk=0, cnt++. After the phase B tick for cnt=N-1, go to DONE.
  - DONE: one clock. Commit result, then return to IDLE.
- The first sampled bit ends up as joy_out MSB, i.e. player 0 bit BITS-1.
- Presence: if a player's raw slice is all-zero after inversion of nothing (joy_data low for all its BITS samples), present[p]=0 and that slice is forced to 0. Otherwise present[p]=1.
- Commit:
  - FILTER=0: always write joy_out/present and pulse upd.
  - FILTER=1: write and pulse only if raw equals the previous frame's raw. The previous raw is always updated.
- en low at any time: next clock the FSM goes to IDLE, joy_clk=0, joy_load=1, joy_out=0, present=0, prev raw=0, upd=0. Any partial frame is discarded.
- trig only matters in IDLE. Changes during a frame are ignored.

## Timing
- Reset values: joy_clk=0, joy_load=1, joy_out=0, present=0, upd=0, busy=0, state IDLE, div=0, cnt=0.
- joy_load low width: exactly CLKDIV clocks. joy_clk high and low widths: CLKDIV clocks each.
- Latency: from the start tick to the upd pulse is (2+2N)*CLKDIV+1 clocks.
- Continuous mode: the next frame starts on the first tick after DONE.
- All outputs are registered. joy_clk and joy_load are glitch-free.
- Sampling occurs on the phase A tick, CLKDIV clocks after the previous falling edge of joy_clk (or load release), so data has been stable for CLKDIV clocks.
- rst mid-frame: all registers return to reset values immediately (asynchronous).

## Test plan
- PLAYERS=2, BITS=12, CLKDIV=4, trig=1, model chain returns 0xFFF for P0 and 0xFFF for P1 (no buttons pressed) -> upd at clock 201 after the start tick; joy_out=0, present=2'b11.
- Same setup, P0 serial pattern 0x7FE (bits 11 and 0 pressed) -> joy_out[23:12]=0x801, joy_out[11:0]=0.
- P1 chain held low (all 12 samples 0) -> present=2'b01, joy_out[11:0]=0 while P0 decodes normally.
- FILTER=1, glitch frame (P0 bit 5 low once), then clean frames -> no joy_out change on the glitch frame; upd only on the second identical frame.
- en dropped at SHIFT cnt=7 -> next clock joy_clk=0, joy_load=1, joy_out=0, busy=0; re-enable gives a full new frame.
- trig pulsed for one tick only -> exactly one frame and one upd; check joy_load low width=4 and joy_clk period=8 clocks.

Source files
------------

// File: rtl/jtframe_serjoy.sv
// Serial joystick reader for a daisy chain of 74HC165-style PISO registers
// (DB15 SNAC adapter). Loads the chain, shifts PLAYERS*BITS bits out, decodes
// active-low buttons, detects pad presence and optionally filters glitches.

// Per-pad decode: presence detection and slice clearing for absent pads.
module jtframe_serjoy_pad #(
    parameter int BITS = 12
)(
    input  logic [BITS-1:0] raw,
    output logic [BITS-1:0] clean,
    output logic            present
);
    // raw holds inverted samples: all ones means the data line never went
    // high, which is what an unplugged pad looks like.
    assign present = ~&raw;
    assign clean   = present ? raw : '0;
endmodule

module jtframe_serjoy #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int CLKDIV  = 8,
    parameter int FILTER  = 0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    trig,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joy_out,
    output logic [PLAYERS-1:0]      present,
    output logic                    upd,
    output logic                    busy
);
    localparam int N  = PLAYERS * BITS;
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          st, st_nxt;
    logic [DW-1:0]   div;
    logic            tick;
    logic            phase;     // LOAD: 0=load pulse, 1=settle; SHIFT: 0=A, 1=B
    logic [CW-1:0]   cnt;
    logic [N-1:0]    raw, prev_raw, clean;
    logic [PLAYERS-1:0] pres_c;

    assign tick = (div == DW'(CLKDIV - 1));

    // Free-running tick divider, independent of the scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DW'(1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    // Next-state logic; dropping en aborts any frame in progress
    always_comb begin
        st_nxt = st;
        if (!en) begin
            st_nxt = IDLE;
        end else begin
            case (st)
                IDLE:  if (tick && trig) st_nxt = LOAD;
                LOAD:  if (tick && phase) st_nxt = SHIFT;
                SHIFT: if (tick && phase && cnt == CW'(N - 1)) st_nxt = DONE;
                DONE:  st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // Per-pad presence check and slice clearing
    genvar p;
    generate
        for (p = 0; p < PLAYERS; p++) begin : g_pad
            localparam int HI = (PLAYERS - p) * BITS - 1;
            jtframe_serjoy_pad #(.BITS(BITS)) u_pad (
                .raw     (raw[HI -: BITS]),
                .clean   (clean[HI -: BITS]),
                .present (pres_c[p])
            );
        end
    endgenerate

    // Chain control, shift register and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 1'b0;
            cnt      <= '0;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
            raw      <= '0;
            prev_raw <= '0;
            joy_out  <= '0;
            present  <= '0;
            upd      <= 1'b0;
        end else if (!en) begin
            phase    <= 1'b0;
            cnt      <= '0;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
            prev_raw <= '0;
            joy_out  <= '0;
            present  <= '0;
            upd      <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (st)
                IDLE: phase <= 1'b0;
                LOAD: if (tick) begin
                    phase    <= ~phase;
                    joy_load <= phase;          // low on first tick, released on second
                    cnt      <= '0;
                end
                SHIFT: if (tick) begin
                    phase <= ~phase;
                    if (!phase) begin
                        raw     <= {raw[N-2:0], ~joy_data};
                        joy_clk <= 1'b1;
                    end else begin
                        joy_clk <= 1'b0;
                        cnt     <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    prev_raw <= raw;
                    if (FILTER == 0 || raw == prev_raw) begin
                        joy_out <= clean;
                        present <= pres_c;
                        upd     <= 1'b1;
                    end
                end
                default: phase <= 1'b0;
            endcase
        end
    end

    // Registered busy flag so it never glitches on state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= (st_nxt != IDLE);
    end
endmodule

// File: tb/tb_jtframe_serjoy.sv
// Bench for jtframe_serjoy: two instances (FILTER=0/1) driven by a model
// 74HC165 chain, checked against a word-level reference model.
module tb_jtframe_serjoy;
    localparam int PL = 2, BT = 12, CD = 4, N = PL * BT;

    logic clk = 0, rst = 1, en = 0, trig = 0;
    logic jd0, jd1, jc0, jc1, jl0, jl1, up0, up1, bz0, bz1;
    logic [N-1:0]  jo0, jo1;
    logic [PL-1:0] pr0, pr1;

    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    jtframe_serjoy #(.PLAYERS(PL), .BITS(BT), .CLKDIV(CD), .FILTER(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .joy_data(jd0),
        .joy_clk(jc0), .joy_load(jl0), .joy_out(jo0), .present(pr0),
        .upd(up0), .busy(bz0));

    jtframe_serjoy #(.PLAYERS(PL), .BITS(BT), .CLKDIV(CD), .FILTER(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .joy_data(jd1),
        .joy_clk(jc1), .joy_load(jl1), .joy_out(jo1), .present(pr1),
        .upd(up1), .busy(bz1));

    // Chain model: serial word, first bit out = MSB = player 0 bit BITS-1
    logic [N-1:0] chain = '1;
    logic [N-1:0] sr0 = '1, sr1 = '1;
    logic pc0 = 0, pc1 = 0;
    assign jd0 = sr0[N-1];
    assign jd1 = sr1[N-1];

    always @(negedge clk) begin
        if (!jl0) sr0 = chain; else if (jc0 && !pc0) sr0 = sr0 << 1;
        if (!jl1) sr1 = chain; else if (jc1 && !pc1) sr1 = sr1 << 1;
        pc0 = jc0;
        pc1 = jc1;
    end

    // Reference state for the filtered instance
    logic [N-1:0]  f_prev = '0, f_out = '0;
    logic [PL-1:0] f_pres = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode a serial word: pressed buttons are 0 on the wire; an all-zero
    // slice means no pad.
    function automatic void decode(input logic [N-1:0] w, output logic [N-1:0] o,
                                   output logic [PL-1:0] pr);
        logic [BT-1:0] s;
        o = '0; pr = '0;
        for (int p = 0; p < PL; p++) begin
            s = w[(PL-p)*BT-1 -: BT];
            if (s != '0) begin
                pr[p] = 1'b1;
                o[(PL-p)*BT-1 -: BT] = ~s;
            end
        end
    endfunction

    // Run one frame with chain word w and check timing and both instances
    task automatic run_frame(input logic [N-1:0] w, input bit pulse);
        logic [N-1:0] eo; logic [PL-1:0] ep; logic eu1;
        int ld_fall = -1, r1 = -1, r2 = -1, ld_low = 0, hi = 0, rises = 0, lat = -1;
        logic pl, pc, got;
        logic [N-1:0] o1; logic [PL-1:0] p1; logic u1;
        chain = w;
        decode(w, eo, ep);
        eu1 = (~w == f_prev);
        if (eu1) begin f_out = eo; f_pres = ep; end
        f_prev = ~w;
        pl = jl0; pc = jc0; got = 0; o1 = '0; p1 = '0; u1 = 0;
        if (pulse) trig = 1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (pulse && i == CD - 1) trig = 0;
            if (!jl0) ld_low++;
            if (pl && !jl0) ld_fall = i;
            if (jc0 && !pc) begin
                rises++;
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (jc0) hi++;
            pl = jl0; pc = jc0;
            if (up0) begin
                got = 1; lat = i - ld_fall;
                o1 = jo1; p1 = pr1; u1 = up1;
            end
        end
        chk("upd_seen", 32'(got), 32'd1);
        chk("latency_from_load", 32'(lat), 32'((1 + 2*N)*CD + 1));
        chk("load_low_width", 32'(ld_low), 32'(CD));
        chk("clk_rises", 32'(rises), 32'(N));
        chk("clk_high_total", 32'(hi), 32'(N*CD));
        chk("clk_period", 32'(r2 - r1), 32'(2*CD));
        chk("joy_out", 32'(jo0), 32'(eo));
        chk("present", 32'(pr0), 32'(ep));
        chk("flt_upd", 32'(u1), 32'(eu1));
        chk("flt_joy_out", 32'(o1), 32'(f_out));
        chk("flt_present", 32'(p1), 32'(f_pres));
    endtask

    logic [N-1:0] w, a, g;
    int cnt_upd, rises;
    logic pc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_joy_clk", 32'(jc0), 0);
        chk("rst_joy_load", 32'(jl0), 1);
        chk("rst_joy_out", 32'(jo0), 0);
        chk("rst_present", 32'(pr0), 0);
        chk("rst_upd", 32'(up0), 0);
        chk("rst_busy", 32'(bz0), 0);
        rst = 0;

        // Continuous scan, no buttons pressed
        chain = '1;
        trig = 1;
        @(negedge clk);
        en = 1;
        run_frame({12'hFFF, 12'hFFF}, 0);
        // Bits 11 and 0 of P0 pressed
        run_frame({12'h7FE, 12'hFFF}, 0);
        // P1 held low: absent
        run_frame({12'h7FE, 12'h000}, 0);

        // Filter: repeat, glitch, then clean frames
        a = {12'h5A5, 12'hFF0};
        g = a; g[BT+5] = 1'b0;
        run_frame(a, 0);
        run_frame(a, 0);
        run_frame(g, 0);
        run_frame(a, 0);
        run_frame(a, 0);

        // Randomised frames with repeats and absent pads
        w = a;
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 3))
                0: ;
                1: begin w = N'($urandom()); w[BT-1:0] = '0; end
                2: begin w = N'($urandom()); w[N-1 -: BT] = '0; end
                default: w = N'($urandom());
            endcase
            run_frame(w, 0);
        end

        // Drop en mid-shift after the 8th rising joy_clk (cnt=7)
        chain = {12'h0F0, 12'h123};
        rises = 0; pc = jc0;
        for (int i = 0; i < 400 && rises < 8; i++) begin
            @(negedge clk);
            if (jc0 && !pc) rises++;
            pc = jc0;
        end
        chk("abort_reached", 32'(rises), 8);
        en = 0;
        @(negedge clk);
        chk("abort_joy_clk", 32'(jc0), 0);
        chk("abort_joy_load", 32'(jl0), 1);
        chk("abort_joy_out", 32'(jo0), 0);
        chk("abort_present", 32'(pr0), 0);
        chk("abort_busy", 32'(bz0), 0);
        chk("abort_flt_out", 32'(jo1), 0);
        f_prev = '0; f_out = '0; f_pres = '0;
        repeat (5) @(negedge clk);
        en = 1;
        run_frame({12'h0F0, 12'h123}, 0);

        // Triggered mode: nothing without trig, one frame for a one-tick pulse
        trig = 0;
        repeat (40) @(negedge clk);
        chk("trig_low_idle", 32'(bz0), 0);
        run_frame({12'hABC, 12'hDEF}, 1);
        cnt_upd = 0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (up0) cnt_upd++;
        end
        chk("single_frame_only", 32'(cnt_upd), 0);
        chk("idle_after_pulse", 32'(bz0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
